// File: rtl/instr_decode_buffer_if.sv
// Fetch/decode handshake bundle for instr_decode_buffer.
// The slave modport is the buffer itself; the master modport is its environment.
interface instr_decode_buffer_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
);
  logic [31:0]             instr_in;
  logic [XLEN-1:0]         pc_in;
  logic                    in_valid_in;
  logic                    in_ready_out;
  logic                    out_valid_out;
  logic                    out_ready_in;
  logic [6:0]              opcode_out;
  logic [2:0]              funct3_out;
  logic [6:0]              funct7_out;
  logic [4:0]              rs1_addr_out;
  logic [4:0]              rs2_addr_out;
  logic [4:0]              rd_addr_out;
  logic [11:0]             csr_addr_out;
  logic [31:0]             imm_out;
  logic [XLEN-1:0]         pc_out;
  logic                    illegal_out;
  logic [$clog2(DEPTH):0]  count_out;

  modport master (
    output instr_in, pc_in, in_valid_in, out_ready_in,
    input  in_ready_out, out_valid_out, opcode_out, funct3_out, funct7_out, rs1_addr_out,
           rs2_addr_out, rd_addr_out, csr_addr_out, imm_out, pc_out, illegal_out, count_out
  );

  modport slave (
    input  instr_in, pc_in, in_valid_in, out_ready_in,
    output in_ready_out, out_valid_out, opcode_out, funct3_out, funct7_out, rs1_addr_out,
           rs2_addr_out, rd_addr_out, csr_addr_out, imm_out, pc_out, illegal_out, count_out
  );
endinterface

// File: rtl/instr_decode_buffer.sv
// Fetch-to-decode FIFO that decodes its head entry into RV32I fields and immediates.
// Empty or flushing presents a NOP decode with pc_out holding its last shown value.
module instr_decode_buffer #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input logic                  clk_in,
  input logic                  reset_in,
  input logic                  flush_in,
  instr_decode_buffer_if.slave bus
);
  localparam int unsigned     PtrW = $clog2(DEPTH);
  localparam int unsigned     CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  logic [31:0]     r_instr_mem [DEPTH];
  logic [XLEN-1:0] r_pc_mem    [DEPTH];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [CntW-1:0] r_count;
  logic [XLEN-1:0] r_pc_last;

  logic            w_in_ready;
  logic            w_out_valid;
  logic            w_push;
  logic            w_pop;
  logic [31:0]     w_instr;
  logic [XLEN-1:0] w_pc;
  logic [31:0]     w_imm;
  logic            w_known;

  assign w_in_ready  = (r_count != Full) && !flush_in;
  assign w_out_valid = (r_count != '0) && !flush_in;
  assign w_push      = bus.in_valid_in && w_in_ready;
  assign w_pop       = w_out_valid && bus.out_ready_in;

  always_ff @(posedge clk_in) begin
    if (reset_in || flush_in) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; the count alone decides what is visible.
  always_ff @(posedge clk_in) begin
    if (w_push && !reset_in) begin
      r_instr_mem[r_wptr] <= bus.instr_in;
      r_pc_mem[r_wptr]    <= bus.pc_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) r_pc_last <= '0;
    else          r_pc_last <= w_pc;
  end

  assign w_instr = w_out_valid ? r_instr_mem[r_rptr] : NOP_INSTR;
  assign w_pc    = w_out_valid ? r_pc_mem[r_rptr]    : r_pc_last;

  always_comb begin
    w_imm   = '0;
    w_known = 1'b1;
    case (w_instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011:
        w_imm = {{20{w_instr[31]}}, w_instr[31:20]};
      7'b0100011:
        w_imm = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
      7'b1100011:
        w_imm = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        w_imm = {w_instr[31:12], 12'b0};
      7'b1101111:
        w_imm = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21],
                 1'b0};
      7'b0110011, 7'b0001111:
        w_imm = '0;
      default:
        w_known = 1'b0;
    endcase
  end

  assign bus.in_ready_out  = w_in_ready;
  assign bus.out_valid_out = w_out_valid;
  assign bus.opcode_out    = w_instr[6:0];
  assign bus.funct3_out    = w_instr[14:12];
  assign bus.funct7_out    = w_instr[31:25];
  assign bus.rs1_addr_out  = w_instr[19:15];
  assign bus.rs2_addr_out  = w_instr[24:20];
  assign bus.rd_addr_out   = w_instr[11:7];
  assign bus.csr_addr_out  = w_instr[31:20];
  assign bus.imm_out       = w_imm;
  assign bus.pc_out        = w_pc;
  assign bus.illegal_out   = w_out_valid && ((w_instr[1:0] != 2'b11) || !w_known);
  assign bus.count_out     = r_count;
endmodule

// File: doc/instr_decode_buffer.md
Name: instr_decode_buffer

Overview:
- Parametrised fetch-to-decode stage that succeeds the purely combinational field splitter.
- Buffers fetched {pc, instruction} pairs in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
- Decodes the head entry into opcode, funct, register, CSR and sign-extended immediate fields, plus an illegal-instruction flag.
- Flush empties the buffer and presents a canonical NOP. Sits between the fetch unit and the register-file/control decode.

Parameters:
- XLEN, 32, PC width in bits.
- DEPTH, 2, FIFO entries. Power of two, ≥2.
- NOP_INSTR, 32'h00000013, instruction presented when empty or flushing (ADDI x0,x0,0).

Ports:
- clk_in  input  1  system clock, rising edge
- reset_in  input  1  synchronous, active-high reset
- flush_in  input  1  discard all buffered instructions
- instr_in  input  32  fetched instruction
- pc_in  input  XLEN  PC of instr_in
- in_valid_in  input  1  fetch offers instr_in/pc_in
- in_ready_out  output  1  buffer accepts this cycle
- out_valid_out  output  1  head entry valid
- out_ready_in  input  1  decode consumes head
- opcode_out  output  7  head instr[6:0]
- funct3_out  output  3  head instr[14:12]
- funct7_out  output  7  head instr[31:25]
- rs1_addr_out  output  5  head instr[19:15]
- rs2_addr_out  output  5  head instr[24:20]
- rd_addr_out  output  5  head instr[11:7]
- csr_addr_out  output  12  head instr[31:20]
- imm_out  output  32  sign-extended immediate of head
- pc_out  output  XLEN  PC of head
- illegal_out  output  1  head valid and not a supported RV32I encoding
- count_out  output  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Clock and reset: one clock (clk_in). reset_in is synchronous and active-high; it is sampled on the clk_in rising edge only.
- Reset: count=0, read/write pointers=0. Next cycle: out_valid_out=0, in_ready_out=1, pc_out=0, illegal_out=0, imm_out=0, and all field outputs show NOP_INSTR decode (opcode=7'h13, all other fields 0).
- Push: on an edge where in_valid_in && in_ready_out, write at wptr and advance wptr (wraps modulo DEPTH).
- Pop: on an edge where out_valid_out && out_ready_in, advance rptr.
- Counting: simultaneous push and pop leaves count unchanged.
- in_ready_out = (count != DEPTH) && !flush_in. There is no combinational path from out_ready_in. Full throughput (1 instr/cycle) holds for DEPTH≥2.
- out_valid_out = (count != 0) && !flush_in.
- Latency: an instruction accepted at edge N appears at the outputs in cycle N+1 when the buffer was empty. There is no same-cycle bypass.
- Decode is combinational from the head entry (registered storage to output).
  - Source instruction: when !out_valid_out, decode NOP_INSTR with pc_out held at its last value.
  - Field outputs are direct bit slices.
- imm_out by opcode:
  - I (0010011, 0000011, 1100111, 1110011): sext(instr[31:20]).
  - S (0100011): sext({instr[31:25], instr[11:7]}).
  - B (1100011): sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U (0110111, 0010111): {instr[31:12], 12'b0}.
  - J (1101111): sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - Otherwise (incl. R, 0110011): 0.
- illegal_out = out_valid_out && (instr[1:0] != 2'b11 || opcode not in {I, S, B, U, J, R, 0001111}). An illegal entry is still delivered and popped normally; the flag is informational.
- Flush:
  - Combinationally in the flush cycle: out_valid_out=0, in_ready_out=0, NOP fields shown.
  - At the edge: count=0, rptr=wptr=0; any concurrent push and pop are discarded.
  - Next cycle: in_ready_out=1.
- Priority: reset_in > flush_in > push/pop.
- Full: a push attempt is refused (in_ready_out=0) and the data is not written, even if a pop occurs in the same cycle.
- Empty: a pop request is ignored (out_valid_out=0).
- Reset or flush mid-stream loses all entries; nothing is partially retained.

Test Plan:
- Reset then idle → out_valid_out=0, in_ready_out=1, opcode_out=7'h13, imm_out=0, count_out=0.
- Push 32'h00500093 (addi x1,x0,5) at pc 0x100, out_ready_in=0 → next cycle out_valid_out=1, rd=1, rs1=0, imm_out=5, pc_out=0x100, count_out=1.
- DEPTH=2, out_ready_in=0, push three instructions → third refused (in_ready_out=0 after 2nd), count_out=2. Then out_ready_in=1 continuously → FIFO order preserved, pointer wrap verified.
- Streaming with in_valid_in=out_ready_in=1 for 8 cycles → one instruction per cycle, count_out constant at 1.
- Immediates:
  - 32'hFE20AE23 (sw x2,-4(x1)) → imm_out=32'hFFFFFFFC.
  - 32'hFE0008E3 (beq, −16) → imm_out=32'hFFFFFFF0.
  - 32'h123450B7 (lui) → imm_out=32'h12345000.
  - 32'h0000006F (jal 0) → imm_out=0.
  - 32'h00000001 → illegal_out=1.
- Buffer holding 2 entries, assert flush_in with in_valid_in=1 for one cycle → out_valid_out=0 and in_ready_out=0 that cycle, count_out=0 next cycle, flushed and incoming data never appear. Repeat with reset_in and flush_in together → reset values.
